// File: rtl/lab2_result_buffer.sv
// lab2_result_buffer: first-word-fallthrough result FIFO behind the lab-2 AND stage.
// Optional feature macro: LAB2_BUF_DROP_EN enables the saturating drop counter;
// when undefined, drop_cnt is tied to zero.
module lab2_result_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Handshake decode from registered occupancy only
  always_comb begin
    in_ready  = (count != CNT_W'(DEPTH));
    out_valid = (count != CNT_W'(0));
    push      = in_valid && in_ready && !rst;
    pop       = out_valid && out_ready && !rst;
    out_data  = mem[rd_ptr];
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

`ifdef LAB2_BUF_DROP_EN
  // Saturating count of words offered while full
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_lab2_result_buffer.sv
// tb_lab2_result_buffer: directed and scoreboard checks for lab2_result_buffer.
module tb_lab2_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];

`ifdef LAB2_BUF_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  lab2_result_buffer #(.DATA_W(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic do_push;
    logic do_pop;

    // Reset held two cycles with a word offered
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Single word in and out
    in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h3C);
    check("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_count", 32'(count), 32'd0);
    check("single_pop_valid", 32'(out_valid), 32'd0);

    // Fill to full, offer one more, then drain in order
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      step();
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h05;
    step();
    in_valid = 1'b0;
    check("full_reject_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(count), 32'd0);

    // Streaming with pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'(8'h10 + i); in_valid = 1'b1;
      step();
      check("stream_data", 32'(out_data), 32'(8'h10 + i));
      check("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream_end_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 2
    in_valid = 1'b1;
    in_data = 8'h20; step();
    in_data = 8'h21; step();
    check("sim_pre_count", 32'(count), 32'd2);
    in_data = 8'h22; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("sim_count", 32'(count), 32'd2);
    check("sim_head", 32'(out_data), 32'h21);
    step();
    check("sim_next", 32'(out_data), 32'h22);
    check("sim_next_count", 32'(count), 32'd1);
    step();
    out_ready = 1'b0;
    check("sim_empty", 32'(count), 32'd0);

    // Random traffic against a queue scoreboard
    q.delete();
    for (int c = 0; c < 200; c++) begin
      check("rnd_count", 32'(count), 32'(q.size()));
      check("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("rnd_in_ready", 32'(in_ready), 32'(q.size() != 4));
      if (q.size() != 0) check("rnd_data", 32'(out_data), 32'(q[0]));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      do_push = in_valid && (q.size() != 4);
      do_pop  = out_ready && (q.size() != 0);
      step();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Mid-test reset with a word offered
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);

    // Fill, then hold in_valid while full
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h40 + i); in_valid = 1'b1;
      step();
    end
    in_data = 8'hEE;
    for (int i = 0; i < 10; i++) step();
    check("drop_10", 32'(drop_cnt), DROP_EN ? 32'd10 : 32'd0);
    for (int i = 0; i < 290; i++) step();
    in_valid = 1'b0;
    check("drop_sat", 32'(drop_cnt), DROP_EN ? 32'd255 : 32'd0);
    check("drop_full_count", 32'(count), 32'd4);
    check("drop_head", 32'(out_data), 32'h40);

    // Final reset clears drop counter and occupancy
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("final_rst_drop", 32'(drop_cnt), 32'd0);
    check("final_rst_count", 32'(count), 32'd0);
    check("final_rst_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
